alarm_sequencer: RTL and testbench

Sequential arm/disarm controller for the house alarm datapath. It takes arm/disarm commands and the door and window sensor inputs, and sequences exit delay, armed, entry delay and alarm/siren phases. Outputs are registered, Moore-decoded status lines (`secure`, `alarm`, `siren`, `chime`) for the annunciator and siren driver.

---
 rtl/alarm_pkg.sv | 27 ++
 rtl/alarm_timer.sv | 38 +++
 rtl/alarm_sequencer.sv | 140 ++++++++++++++
 tb/tb_alarm_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// State encoding and helpers shared by the alarm sequencer and its bench-visible debug port.
package alarm_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] DISARMED    = 3'd0;
    localparam logic [STATE_W-1:0] EXIT_DELAY  = 3'd1;
    localparam logic [STATE_W-1:0] ARMED       = 3'd2;
    localparam logic [STATE_W-1:0] ENTRY_DELAY = 3'd3;
    localparam logic [STATE_W-1:0] ALARM       = 3'd4;
    localparam logic [STATE_W-1:0] HOLD        = 3'd5;

    typedef enum logic [STATE_W-1:0] {
        ST_DISARMED    = DISARMED,
        ST_EXIT_DELAY  = EXIT_DELAY,
        ST_ARMED       = ARMED,
        ST_ENTRY_DELAY = ENTRY_DELAY,
        ST_ALARM       = ALARM,
        ST_HOLD        = HOLD
    } state_e;

    // States that run the shared delay counter
    function automatic logic is_timed(input state_e st);
        return (st == ST_EXIT_DELAY) || (st == ST_ENTRY_DELAY) || (st == ST_ALARM);
    endfunction

endpackage

// File: rtl/alarm_timer.sv
// Loadable down-counter with zero flag; load wins over enable, saturates at zero.
// Latency: count changes the cycle after load/en; done is decoded from the register.
module alarm_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign done  = (count_q == '0);

endmodule

// File: rtl/alarm_sequencer.sv
// Arm/disarm sequencer: exit delay, armed, entry delay, siren, latched hold.
// Latency: all outputs registered, one cycle after the qualifying input; no backpressure.
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int EXIT_DLY  = 8,
    parameter int ENTRY_DLY = 8,
    parameter int SIREN_LEN = 16,
    parameter int CNT_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               arm,
    input  logic               stay,
    input  logic               disarm,
    input  logic [1:0]         doors,
    input  logic [2:0]         windows,
    output logic               secure,
    output logic               alarm,
    output logic               siren,
    output logic               chime,
    output logic [STATE_W-1:0] state_o
);

    localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_DLY - 1);
    localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_DLY - 1);
    localparam logic [CNT_W-1:0] SIREN_LD = CNT_W'(SIREN_LEN - 1);

    state_e state_q, state_d;
    logic   mode_q, mode_d;
    logic   secure_q, secure_d;
    logic   alarm_q, alarm_d;
    logic   siren_q, siren_d;
    logic   chime_q, chime_d;

    logic             win_trip;
    logic             door_trip;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_en;
    logic [CNT_W-1:0] tmr_count;
    logic             tmr_done;

    assign win_trip  = |windows;
    assign door_trip = |doors;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        case (state_q)
            ST_DISARMED: begin
                if (arm && !disarm) begin
                    state_d = ST_EXIT_DELAY;
                    mode_d  = stay;
                end
            end
            ST_EXIT_DELAY: begin
                // Doors deliberately ignored so the occupant can walk out
                if (disarm)        state_d = ST_DISARMED;
                else if (win_trip) state_d = ST_ALARM;
                else if (tmr_done) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (disarm)         state_d = ST_DISARMED;
                else if (win_trip)  state_d = ST_ALARM;
                else if (door_trip) state_d = mode_q ? ST_ALARM : ST_ENTRY_DELAY;
            end
            ST_ENTRY_DELAY: begin
                if (disarm)        state_d = ST_DISARMED;
                else if (win_trip) state_d = ST_ALARM;
                else if (tmr_done) state_d = ST_ALARM;
            end
            ST_ALARM: begin
                if (disarm)        state_d = ST_DISARMED;
                else if (tmr_done) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (disarm) state_d = ST_DISARMED;
            end
            default: state_d = ST_DISARMED;
        endcase
    end

    // Any state change reloads the counter: the delay for a timed target, zero otherwise
    always_comb begin
        tmr_load     = (state_d != state_q);
        tmr_load_val = '0;
        case (state_d)
            ST_EXIT_DELAY:  tmr_load_val = EXIT_LD;
            ST_ENTRY_DELAY: tmr_load_val = ENTRY_LD;
            ST_ALARM:       tmr_load_val = SIREN_LD;
            default:        tmr_load_val = '0;
        endcase
        tmr_en = !tmr_load && is_timed(state_q);
    end

    always_comb begin
        secure_d = (state_d == ST_ARMED);
        alarm_d  = (state_d == ST_ALARM) || (state_d == ST_HOLD);
        siren_d  = (state_d == ST_ALARM);
        chime_d  = (state_d == ST_EXIT_DELAY) || (state_d == ST_ENTRY_DELAY);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_DISARMED;
            mode_q   <= 1'b0;
            secure_q <= 1'b0;
            alarm_q  <= 1'b0;
            siren_q  <= 1'b0;
            chime_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            secure_q <= secure_d;
            alarm_q  <= alarm_d;
            siren_q  <= siren_d;
            chime_q  <= chime_d;
        end
    end

    alarm_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .en       (tmr_en),
        .count    (tmr_count),
        .done     (tmr_done)
    );

    assign secure  = secure_q;
    assign alarm   = alarm_q;
    assign siren   = siren_q;
    assign chime   = chime_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed test-plan scenarios plus random traffic against a phase/elapsed-time reference model.
module tb_alarm_sequencer;

    localparam int EXIT_DLY  = 8;
    localparam int ENTRY_DLY = 8;
    localparam int SIREN_LEN = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       arm, stay, disarm;
    logic [1:0] doors;
    logic [2:0] windows;
    logic       secure, alarm, siren, chime;
    logic [2:0] state_o;

    int checks = 0;
    int errors = 0;

    // Reference model: current phase, cycles already spent in it, latched mode
    int m_phase;
    int m_elapsed;
    bit m_stay;

    always #5 clk = ~clk;

    alarm_sequencer #(
        .EXIT_DLY  (EXIT_DLY),
        .ENTRY_DLY (ENTRY_DLY),
        .SIREN_LEN (SIREN_LEN),
        .CNT_W     (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .arm     (arm),
        .stay    (stay),
        .disarm  (disarm),
        .doors   (doors),
        .windows (windows),
        .secure  (secure),
        .alarm   (alarm),
        .siren   (siren),
        .chime   (chime),
        .state_o (state_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase   = 0;
        m_elapsed = 0;
        m_stay    = 1'b0;
    endtask

    function automatic int phase_len(input int p);
        case (p)
            1:       return EXIT_DLY;
            3:       return ENTRY_DLY;
            4:       return SIREN_LEN;
            default: return 0;
        endcase
    endfunction

    task automatic model_step(input bit a, input bit s, input bit d, input logic [1:0] dr, input logic [2:0] w);
        int  nxt;
        bit  last;
        nxt  = m_phase;
        last = (phase_len(m_phase) != 0) && (m_elapsed + 1 >= phase_len(m_phase));
        if (m_phase == 0) begin
            if (a && !d) begin
                nxt    = 1;
                m_stay = s;
            end
        end else if (d) begin
            nxt = 0;
        end else if (w != 0 && m_phase >= 1 && m_phase <= 3) begin
            nxt = 4;
        end else if (m_phase == 2 && dr != 0) begin
            nxt = m_stay ? 4 : 3;
        end else if (last) begin
            nxt = (m_phase == 1) ? 2 : (m_phase == 3) ? 4 : 5;
        end
        if (nxt != m_phase) m_elapsed = 0;
        else                m_elapsed++;
        m_phase = nxt;
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".state"},  {29'd0, state_o}, m_phase);
        chk({tag, ".secure"}, {31'd0, secure},  (m_phase == 2) ? 1 : 0);
        chk({tag, ".alarm"},  {31'd0, alarm},   (m_phase == 4 || m_phase == 5) ? 1 : 0);
        chk({tag, ".siren"},  {31'd0, siren},   (m_phase == 4) ? 1 : 0);
        chk({tag, ".chime"},  {31'd0, chime},   (m_phase == 1 || m_phase == 3) ? 1 : 0);
    endtask

    // Called at a negedge: drive, clock, update model, compare on the next negedge
    task automatic step(input string tag, input bit a, input bit s, input bit d,
                        input logic [1:0] dr, input logic [2:0] w);
        arm = a; stay = s; disarm = d; doors = dr; windows = w;
        @(posedge clk);
        model_step(a, s, d, dr, w);
        @(negedge clk);
        compare_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 2'b00, 3'b000);
    endtask

    task automatic arm_and_wait(input bit s);
        step("arm", 1, s, 0, 2'b00, 3'b000);
        idle("exit", EXIT_DLY);
        chk("armed_secure", {31'd0, secure}, 1);
    endtask

    initial begin
        arm = 0; stay = 0; disarm = 0; doors = '0; windows = '0;
        reset = 1'b1;
        model_reset();
        #1;
        compare_all("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Exit delay: exactly EXIT_DLY chime cycles then ARMED
        step("arm_away", 1, 0, 0, 2'b00, 3'b000);
        chk("exit_chime0", {31'd0, chime}, 1);
        for (int i = 1; i < EXIT_DLY; i++) begin
            step("exit", 0, 0, 0, 2'b00, 3'b000);
            chk("exit_chime", {31'd0, chime}, 1);
        end
        step("exit_end", 0, 0, 0, 2'b00, 3'b000);
        chk("armed_secure", {31'd0, secure}, 1);
        chk("armed_state", {29'd0, state_o}, 2);

        // Away door trip: entry delay, siren, hold, disarm
        step("door_away", 0, 0, 0, 2'b01, 3'b000);
        chk("entry_state", {29'd0, state_o}, 3);
        idle("entry", ENTRY_DLY - 1);
        chk("entry_last_chime", {31'd0, chime}, 1);
        for (int i = 0; i < SIREN_LEN; i++) begin
            step("siren", 0, 0, 0, 2'b00, 3'b000);
            chk("siren_on", {31'd0, siren}, 1);
        end
        step("hold", 0, 0, 0, 2'b00, 3'b000);
        chk("hold_alarm", {31'd0, alarm}, 1);
        chk("hold_siren", {31'd0, siren}, 0);
        idle("hold_stays", 5);
        chk("hold_state", {29'd0, state_o}, 5);
        step("hold_disarm", 0, 0, 1, 2'b00, 3'b000);
        chk("disarm_state", {29'd0, state_o}, 0);

        // Stay mode: door goes straight to ALARM
        arm_and_wait(1'b1);
        step("door_stay", 0, 0, 0, 2'b10, 3'b000);
        chk("stay_door_alarm", {29'd0, state_o}, 4);
        step("disarm", 0, 0, 1, 2'b00, 3'b000);

        // Away mode: window goes straight to ALARM
        arm_and_wait(1'b0);
        step("win_away", 0, 0, 0, 2'b00, 3'b100);
        chk("away_win_alarm", {29'd0, state_o}, 4);
        step("disarm", 0, 0, 1, 2'b00, 3'b000);

        // Exit delay ignores doors, not windows; disarm beats window
        step("arm", 1, 0, 0, 2'b00, 3'b000);
        step("exit_doors", 0, 0, 0, 2'b11, 3'b000);
        chk("exit_door_ignored", {29'd0, state_o}, 1);
        step("exit_win", 0, 0, 0, 2'b00, 3'b001);
        chk("exit_win_alarm", {29'd0, state_o}, 4);
        step("disarm", 0, 0, 1, 2'b00, 3'b000);
        step("arm", 1, 0, 0, 2'b00, 3'b000);
        step("disarm_win", 0, 0, 1, 2'b00, 3'b001);
        chk("disarm_beats_win", {29'd0, state_o}, 0);

        // Disarm during entry delay, and arm+disarm together
        arm_and_wait(1'b0);
        step("door", 0, 0, 0, 2'b01, 3'b000);
        idle("entry", 2);
        step("entry_disarm", 0, 0, 1, 2'b00, 3'b000);
        chk("entry_disarm_state", {29'd0, state_o}, 0);
        chk("entry_disarm_siren", {31'd0, siren}, 0);
        step("arm_disarm", 1, 0, 1, 2'b00, 3'b000);
        chk("arm_disarm_state", {29'd0, state_o}, 0);

        // Async reset mid-siren, then a full exit delay afterwards
        arm_and_wait(1'b0);
        step("door", 0, 0, 0, 2'b01, 3'b000);
        idle("entry", ENTRY_DLY);
        idle("siren", 10);
        chk("pre_reset_siren", {31'd0, siren}, 1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        compare_all("async_reset");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step("rearm", 1, 0, 0, 2'b00, 3'b000);
        for (int i = 1; i < EXIT_DLY; i++) begin
            step("rearm_exit", 0, 0, 0, 2'b00, 3'b000);
            chk("rearm_chime", {31'd0, chime}, 1);
        end
        step("rearm_end", 0, 0, 0, 2'b00, 3'b000);
        chk("rearm_secure", {31'd0, secure}, 1);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit a, s, d;
            logic [1:0] dr;
            logic [2:0] w;
            a  = ($urandom_range(3) == 0);
            s  = $urandom_range(1);
            d  = ($urandom_range(23) == 0);
            dr = ($urandom_range(11) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            w  = ($urandom_range(39) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            step("rand", a, s, d, dr, w);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
